// File: rtl/xc_sha3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xc_sha3_pkg                                            |
// | Description : Shared constants for the sha3 index unit and the lane  |
// |               address sequencer: mode codes, lane count, FSM states. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package xc_sha3_pkg;

   // Number of 64-bit lanes in a Keccak-f[1600] state (5 x 5)
   localparam int LANES = 25;

   // Index function selects carried on the 3-bit mode input
   localparam logic [2:0] SHA3_M_XY = 3'd0;
   localparam logic [2:0] SHA3_M_X1 = 3'd1;
   localparam logic [2:0] SHA3_M_X2 = 3'd2;
   localparam logic [2:0] SHA3_M_X4 = 3'd3;
   localparam logic [2:0] SHA3_M_YX = 3'd4;

   // Sequencer state encodings
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   // Reduce a small value (0..31) modulo 5; operands here never exceed 20
   function automatic logic [2:0] lane_mod5(input logic [4:0] v);
      logic [4:0] r;
      r = v % 5'd5;
      return r[2:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/xc_sha3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xc_sha3                                                |
// | Description : Keccak lane index unit. Maps an (x,y) lane coordinate  |
// |               to a linear lane index with one of five permutations,  |
// |               then shifts it left by shamt (zero-extended to XLEN).  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module xc_sha3
   import xc_sha3_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      rs1,     // x coordinate, 0..4
   input  logic [2:0]      rs2,     // y coordinate, 0..4
   input  logic [1:0]      shamt,
   input  logic            f_xy,
   input  logic            f_x1,
   input  logic            f_x2,
   input  logic            f_x4,
   input  logic            f_yx,
   output logic [XLEN-1:0] result
);

   logic [4:0] w_x_ext;
   logic [4:0] w_y_ext;
   logic [2:0] w_col;
   logic [4:0] w_yx_sum;
   logic [4:0] w_index;

   assign w_x_ext = {2'b00, rs1};
   assign w_y_ext = {2'b00, rs2};

   // Column select and permuted lane index; XY is the fallback column when no rotate is selected
   always_comb begin
      w_col    = rs1;
      w_yx_sum = 5'd2 * w_x_ext + 5'd3 * w_y_ext;
      if (f_x1)
         w_col = lane_mod5(w_x_ext + 5'd1);
      else if (f_x2)
         w_col = lane_mod5(w_x_ext + 5'd2);
      else if (f_x4)
         w_col = lane_mod5(w_x_ext + 5'd4);
      else if (f_xy)
         w_col = rs1;

      if (f_yx)
         w_index = w_y_ext + 5'd5 * {2'b00, lane_mod5(w_yx_sum)};
      else
         w_index = {2'b00, w_col} + 5'd5 * w_y_ext;
   end

   assign result = {{(XLEN-5){1'b0}}, w_index} << shamt;

endmodule
`default_nettype wire

// File: rtl/xc_sha3_lane_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xc_sha3_lane_seq                                       |
// | Description : Walks all 25 Keccak lanes in x-fastest order, forms    |
// |               base + (index << shamt) through xc_sha3 and emits the  |
// |               addresses on a registered valid/ready stream.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module xc_sha3_lane_seq
   import xc_sha3_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int OUT_REG = 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      mode,
   input  logic [1:0]      shamt,
   input  logic [XLEN-1:0] base,
   output logic            busy,
   output logic            addr_valid,
   input  logic            addr_ready,
   output logic [XLEN-1:0] addr,
   output logic [2:0]      addr_x,
   output logic [2:0]      addr_y,
   output logic            addr_last,
   output logic            done
);

   // Highest coordinate on either axis of the square lane grid
   localparam logic [2:0] c_DIM_MAX = 3'(LANES / 5 - 1);

   generate
      if (OUT_REG != 1) begin : g_out_reg_unsupported
         $error("xc_sha3_lane_seq: only OUT_REG=1 is supported");
      end
   endgenerate

   logic [1:0]      r_state;
   logic [1:0]      w_next_state;
   logic [2:0]      r_mode;
   logic [1:0]      r_shamt;
   logic [XLEN-1:0] r_base;
   logic [2:0]      r_x;
   logic [2:0]      r_y;
   logic [XLEN-1:0] r_addr;
   logic [2:0]      r_addr_x;
   logic [2:0]      r_addr_y;
   logic            r_addr_last;
   logic            r_addr_valid;
   logic            r_done;
   logic            w_busy;
   logic            w_load;
   logic            w_xfer;
   logic            w_capture;
   logic            w_at_end;
   logic            w_f_xy;
   logic            w_f_x1;
   logic            w_f_x2;
   logic            w_f_x4;
   logic            w_f_yx;
   logic [XLEN-1:0] w_offset;

   // State register
   always_ff @(posedge g_clk) begin
      if (g_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic; abort returns to IDLE from anywhere
   always_comb begin
      w_next_state = r_state;
      if (abort) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start)              w_next_state = S_RUN;
            S_RUN:   if (w_load && w_at_end) w_next_state = S_DRAIN;
            S_DRAIN: if (w_xfer)             w_next_state = S_IDLE;
            default:                         w_next_state = S_IDLE;
         endcase
      end
   end

   // FSM-derived controls: output register load, handshake, parameter capture
   always_comb begin
      w_busy    = (r_state != S_IDLE);
      w_load    = (r_state == S_RUN) && (!r_addr_valid || addr_ready);
      w_xfer    = r_addr_valid && addr_ready;
      w_capture = (r_state == S_IDLE) && start && !abort;
      w_at_end  = (r_x == c_DIM_MAX) && (r_y == c_DIM_MAX);
   end

   // One-hot index function decode; unused codes fall back to XY
   always_comb begin
      w_f_xy = 1'b0;
      w_f_x1 = 1'b0;
      w_f_x2 = 1'b0;
      w_f_x4 = 1'b0;
      w_f_yx = 1'b0;
      case (r_mode)
         SHA3_M_X1: w_f_x1 = 1'b1;
         SHA3_M_X2: w_f_x2 = 1'b1;
         SHA3_M_X4: w_f_x4 = 1'b1;
         SHA3_M_YX: w_f_yx = 1'b1;
         SHA3_M_XY: w_f_xy = 1'b1;
         default:   w_f_xy = 1'b1;
      endcase
   end

   // Pass parameters are frozen at start so input changes mid-pass are ignored
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_mode  <= SHA3_M_XY;
         r_shamt <= 2'd0;
         r_base  <= '0;
      end else if (w_capture) begin
         r_mode  <= mode;
         r_shamt <= shamt;
         r_base  <= base;
      end
   end

   // Lane counters: x fastest, hold at (4,4) while draining, clear on abort or pass end
   always_ff @(posedge g_clk) begin
      if (g_reset || abort) begin
         r_x <= 3'd0;
         r_y <= 3'd0;
      end else if ((r_state == S_DRAIN) && w_xfer) begin
         r_x <= 3'd0;
         r_y <= 3'd0;
      end else if (w_load && !w_at_end) begin
         if (r_x == c_DIM_MAX) begin
            r_x <= 3'd0;
            r_y <= r_y + 3'd1;
         end else begin
            r_x <= r_x + 3'd1;
         end
      end
   end

   xc_sha3 #(
      .XLEN (XLEN)
   ) u_index (
      .rs1    (r_x),
      .rs2    (r_y),
      .shamt  (r_shamt),
      .f_xy   (w_f_xy),
      .f_x1   (w_f_x1),
      .f_x2   (w_f_x2),
      .f_x4   (w_f_x4),
      .f_yx   (w_f_yx),
      .result (w_offset)
   );

   // Output beat register; abort beats a same-cycle handshake or load
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_addr       <= '0;
         r_addr_x     <= 3'd0;
         r_addr_y     <= 3'd0;
         r_addr_last  <= 1'b0;
         r_addr_valid <= 1'b0;
      end else if (abort) begin
         r_addr_valid <= 1'b0;
         r_addr_last  <= 1'b0;
      end else if (w_load) begin
         r_addr       <= r_base + w_offset;
         r_addr_x     <= r_x;
         r_addr_y     <= r_y;
         r_addr_last  <= w_at_end;
         r_addr_valid <= 1'b1;
      end else if (w_xfer) begin
         r_addr_valid <= 1'b0;
      end
   end

   // Completion pulse in the cycle after the final beat is accepted
   always_ff @(posedge g_clk) begin
      if (g_reset)
         r_done <= 1'b0;
      else
         r_done <= !abort && (r_state == S_DRAIN) && w_xfer;
   end

   assign busy       = w_busy;
   assign addr_valid = r_addr_valid;
   assign addr       = r_addr;
   assign addr_x     = r_addr_x;
   assign addr_y     = r_addr_y;
   assign addr_last  = r_addr_last;
   assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_xc_sha3_lane_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_xc_sha3_lane_seq                                    |
// | Description : Directed self-checking bench for the lane sequencer.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_xc_sha3_lane_seq;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        start;
   logic        abort;
   logic [2:0]  mode;
   logic [1:0]  shamt;
   logic [31:0] base;
   logic        busy;
   logic        addr_valid;
   logic        addr_ready;
   logic [31:0] addr;
   logic [2:0]  addr_x;
   logic [2:0]  addr_y;
   logic        addr_last;
   logic        done;

   int n_pass  = 0;
   int n_total = 0;

   // Per-pass capture of every accepted beat
   logic [31:0] b_addr [25];
   logic [2:0]  b_x    [25];
   logic [2:0]  b_y    [25];
   logic        b_last [25];
   int          b_cyc  [25];
   int          nb;
   int          ndone;

   xc_sha3_lane_seq #(
      .XLEN    (32),
      .OUT_REG (1)
   ) dut (
      .g_clk      (g_clk),
      .g_reset    (g_reset),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .shamt      (shamt),
      .base       (base),
      .busy       (busy),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr       (addr),
      .addr_x     (addr_x),
      .addr_y     (addr_y),
      .addr_last  (addr_last),
      .done       (done)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   // Reference lane index straight from the index-function definitions
   function automatic int exp_idx(input int m, input int x, input int y);
      case (m)
         1:       return ((x + 1) % 5) + 5 * y;
         2:       return ((x + 2) % 5) + 5 * y;
         3:       return ((x + 4) % 5) + 5 * y;
         4:       return y + 5 * ((2 * x + 3 * y) % 5);
         default: return x + 5 * y;
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},  busy,       32'd0);
      chk({tag, "_valid"}, addr_valid, 32'd0);
      chk({tag, "_last"},  addr_last,  32'd0);
      chk({tag, "_done"},  done,       32'd0);
      chk({tag, "_addr"},  addr,       32'd0);
      chk({tag, "_x"},     addr_x,     32'd0);
      chk({tag, "_y"},     addr_y,     32'd0);
   endtask

   // Run one full pass starting in the current cycle; optional ready stall on one beat
   task automatic run_pass(input logic [2:0] m, input logic [1:0] s, input logic [31:0] b,
                           input int stall_beat, input int stall_len, input string tag);
      logic [31:0] h_addr;
      logic [2:0]  h_x;
      logic [2:0]  h_y;
      int          cyc;
      int          stall_cnt;
      mode  = m;
      shamt = s;
      base  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      // Disturb the inputs: the pass must keep using the captured values
      mode  = 3'd4;
      shamt = 2'd0;
      base  = 32'hDEAD_BEEF;
      chk({tag, "_busy1"},  busy,       32'd1);
      chk({tag, "_done0"},  done,       32'd0);
      chk({tag, "_valid0"}, addr_valid, 32'd0);
      nb        = 0;
      ndone     = 0;
      cyc       = 0;
      stall_cnt = 0;
      h_addr    = '0;
      h_x       = '0;
      h_y       = '0;
      while (cyc < 200 && ndone == 0) begin
         if (addr_valid && nb == stall_beat && stall_cnt < stall_len) begin
            addr_ready = 1'b0;
            if (stall_cnt == 0) begin
               h_addr = addr;
               h_x    = addr_x;
               h_y    = addr_y;
            end else begin
               chk({tag, "_hold_addr"}, addr,   h_addr);
               chk({tag, "_hold_x"},    addr_x, {29'd0, h_x});
               chk({tag, "_hold_y"},    addr_y, {29'd0, h_y});
            end
            stall_cnt++;
         end else begin
            addr_ready = 1'b1;
         end
         if (done) begin
            ndone++;
            chk({tag, "_busy_at_done"}, busy, 32'd0);
         end else if (addr_valid && addr_ready) begin
            if (nb < 25) begin
               b_addr[nb] = addr;
               b_x[nb]    = addr_x;
               b_y[nb]    = addr_y;
               b_last[nb] = addr_last;
               b_cyc[nb]  = cyc;
            end
            nb++;
         end
         if (ndone == 0) begin
            tick();
            cyc++;
         end
      end
      chk({tag, "_done_seen"}, ndone,                   32'd1);
      chk({tag, "_beats"},     nb,                      32'd25);
      chk({tag, "_latency"},   b_cyc[0],                32'd1);
      chk({tag, "_span"},      b_cyc[24] - b_cyc[0],    32'(24 + stall_len));
   endtask

   // Compare every captured beat against the reference index function
   task automatic verify_pass(input int m, input logic [1:0] s, input logic [31:0] b, input string tag);
      logic [31:0] e;
      logic [6:0]  got;
      logic [6:0]  want;
      for (int i = 0; i < 25; i++) begin
         e    = b + (32'(exp_idx(m, i % 5, i / 5)) << s);
         got  = {b_x[i], b_y[i], b_last[i]};
         want = {3'(i % 5), 3'(i / 5), (i == 24)};
         chk($sformatf("%s_addr%0d", tag, i), b_addr[i], e);
         chk($sformatf("%s_xyl%0d", tag, i), {25'd0, got}, {25'd0, want});
      end
   endtask

   initial begin
      int cyc;
      g_reset    = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      mode       = 3'd0;
      shamt      = 2'd0;
      base       = 32'd0;
      addr_ready = 1'b1;
      tick();
      tick();
      tick();
      chk_reset_vals("rst");
      g_reset = 1'b0;
      tick();
      chk("idle_busy", busy, 32'd0);

      // XY, 64-bit lanes from 0x1000
      run_pass(3'd0, 2'd3, 32'h0000_1000, -1, 0, "t1");
      verify_pass(0, 2'd3, 32'h0000_1000, "t1");
      chk("t1_first", b_addr[0],  32'h0000_1000);
      chk("t1_final", b_addr[24], 32'h0000_10C0);

      // YX, back-to-back start in the done cycle
      run_pass(3'd4, 2'd3, 32'h0, -1, 0, "t2");
      verify_pass(4, 2'd3, 32'h0, "t2");
      chk("t2_x1y0", b_addr[1],  32'h0000_0050);
      chk("t2_x0y1", b_addr[5],  32'h0000_0080);
      chk("t2_x4y4", b_addr[24], 32'h0000_0020);

      // X1 and X4, unshifted
      run_pass(3'd1, 2'd0, 32'h0, -1, 0, "t3a");
      verify_pass(1, 2'd0, 32'h0, "t3a");
      chk("t3a_x4y2", b_addr[14], 32'h0000_000A);
      run_pass(3'd3, 2'd0, 32'h0, -1, 0, "t3b");
      verify_pass(3, 2'd0, 32'h0, "t3b");
      chk("t3b_x3y1", b_addr[8], 32'h0000_0007);

      // X2 with ready held low for 3 cycles on beat 5
      run_pass(3'd2, 2'd2, 32'h0000_2000, 5, 3, "t4");
      verify_pass(2, 2'd2, 32'h0000_2000, "t4");

      // Address wrap at 2^32
      run_pass(3'd0, 2'd3, 32'hFFFF_FFF8, -1, 0, "t5");
      chk("t5_beat0", b_addr[0], 32'hFFFF_FFF8);
      chk("t5_beat1", b_addr[1], 32'h0000_0000);

      // Reserved mode code behaves as XY
      run_pass(3'd6, 2'd2, 32'h0000_0100, -1, 0, "t7");
      verify_pass(6, 2'd2, 32'h0000_0100, "t7");

      // Abort at beat 10 together with a handshake
      mode  = 3'd0;
      shamt = 2'd3;
      base  = 32'h0000_3000;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      while (!(addr_valid && addr_x == 3'd0 && addr_y == 3'd2) && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("t6_reach_beat10", (cyc < 50), 32'd1);
      chk("t6_beat10_addr", addr, 32'h0000_3050);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t6_valid", addr_valid, 32'd0);
      chk("t6_busy",  busy,       32'd0);
      chk("t6_done",  done,       32'd0);
      // Restart immediately in the cycle after abort
      base  = 32'h0000_4000;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_restart_busy", busy, 32'd1);
      chk("t6_restart_done", done, 32'd0);
      tick();
      chk("t6_restart_valid", addr_valid, 32'd1);
      chk("t6_restart_x",     addr_x,     32'd0);
      chk("t6_restart_y",     addr_y,     32'd0);
      chk("t6_restart_addr",  addr,       32'h0000_4000);
      tick();
      tick();
      tick();
      // Reset mid-pass overrides abort and start
      g_reset = 1'b1;
      abort   = 1'b1;
      start   = 1'b1;
      tick();
      chk_reset_vals("t6_rst");
      g_reset = 1'b0;
      abort   = 1'b0;
      start   = 1'b0;
      tick();
      chk("t6_post_rst_busy", busy, 32'd0);
      // abort wins over start in IDLE
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("t6_abort_start_busy", busy, 32'd0);

      // Clean pass after recovery
      run_pass(3'd0, 2'd0, 32'h0000_0040, -1, 0, "t8");
      verify_pass(0, 2'd0, 32'h0000_0040, "t8");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
